// File: rtl/lsu.sv
// lsu -- load/store unit between EX and the data-memory bus.
//
// Takes one memory access per instruction from EX, issues it on a req/ack
// bus that may insert any number of wait states, and returns the extended
// load result to writeback. Misaligned or unsupported accesses are flagged
// on mem_fault and never reach the bus.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   ex_valid, ex_mem_ena     EX slot valid / instruction touches memory
//   ex_mem_rw                0 = read, 1 = write
//   ex_funct3                000 B, 001 H, 010 W, 100 BU, 101 HU
//   ex_addr, ex_wdata        byte address, store data (low bits)
//   bus_req/we/addr/be/wdata registered bus request
//   bus_ack, bus_rdata       bus completion and read word
//   mem_rw_o, mem_rdata_o    direction and load result for writeback
//   busy                     stall request to cpu_ctrl (combinational)
//   mem_fault                faulting access in EX (combinational)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an access from EX; accepts it in this cycle
// REQ   | bus_req held with stable bus_*; waits for bus_ack
// DONE  | one-cycle completion slot, EX still holds the finished access
module lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_mem_ena,
   input  logic              ex_mem_rw,
   input  logic [2:0]        ex_funct3,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              mem_rw_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              busy,
   output logic              mem_fault
);

   localparam logic MEM_READ = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   state_t              state_q;
   logic                bus_req_q;
   logic                bus_we_q;
   logic [ADDR_W-1:0]   bus_addr_q;
   logic [3:0]          bus_be_q;
   logic [DATA_W-1:0]   bus_wdata_q;
   logic [2:0]          funct3_q;
   logic [1:0]          off_q;
   logic                mem_rw_q;
   logic [DATA_W-1:0]   mem_rdata_q;

   logic                req_hit;
   logic                fault_c;
   logic                accept;
   logic [3:0]          be_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [DATA_W-1:0]   rdata_d;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;

   assign req_hit = ex_valid & ex_mem_ena;

   // Unsigned variants exist only for loads; reserved encodings always fault.
   always_comb begin
      fault_c = 1'b0;
      unique case (ex_funct3)
         3'b000:  fault_c = 1'b0;
         3'b001:  fault_c = ex_addr[0];
         3'b010:  fault_c = |ex_addr[1:0];
         3'b100:  fault_c = ex_mem_rw;
         3'b101:  fault_c = ex_mem_rw | ex_addr[0];
         default: fault_c = 1'b1;
      endcase
   end

   assign accept    = (state_q == S_IDLE) & req_hit & ~fault_c;
   assign mem_fault = (state_q == S_IDLE) & req_hit & fault_c;
   assign busy      = accept | (state_q == S_REQ);

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = ex_wdata;
      unique case (ex_funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << ex_addr[1:0];
            wdata_d = {4{ex_wdata[7:0]}};
         end
         2'b01: begin
            be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{ex_wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = ex_wdata;
         end
      endcase
   end

   // Lane selection uses the offset latched at acceptance, not the live EX
   // address, so the result is independent of what EX does during REQ.
   assign byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
   assign half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      rdata_d = bus_rdata;
      unique case (funct3_q[1:0])
         2'b00:   rdata_d = {{(DATA_W-8){~funct3_q[2] & byte_sel[7]}}, byte_sel};
         2'b01:   rdata_d = {{(DATA_W-16){~funct3_q[2] & half_sel[15]}}, half_sel};
         default: rdata_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= '0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         mem_rw_q    <= MEM_READ;
         mem_rdata_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q     <= S_REQ;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= ex_mem_rw;
                  bus_addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                  bus_be_q    <= be_d;
                  bus_wdata_q <= wdata_d;
                  funct3_q    <= ex_funct3;
                  off_q       <= ex_addr[1:0];
                  mem_rw_q    <= ex_mem_rw;
               end
            end
            S_REQ: begin
               if (bus_ack) begin
                  state_q   <= S_DONE;
                  bus_req_q <= 1'b0;
                  if (!bus_we_q) begin
                     mem_rdata_q <= rdata_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;
   assign mem_rw_o    = mem_rw_q;
   assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_mem_ena;
   logic        ex_mem_rw;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        mem_rw_o;
   logic [31:0] mem_rdata_o;
   logic        busy;
   logic        mem_fault;

   logic        resp_ack;
   logic        man_ack;
   assign bus_ack = resp_ack | man_ack;

   lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_mem_ena  (ex_mem_ena),
      .ex_mem_rw   (ex_mem_rw),
      .ex_funct3   (ex_funct3),
      .ex_addr     (ex_addr),
      .ex_wdata    (ex_wdata),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata),
      .mem_rw_o    (mem_rw_o),
      .mem_rdata_o (mem_rdata_o),
      .busy        (busy),
      .mem_fault   (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   logic [31:0] refmem [0:1023];
   logic [31:0] busmem [0:1023];

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic        rw;
      logic [31:0] rdata;
   } res_exp_t;

   bus_exp_t bus_q[$];
   res_exp_t res_q[$];

   logic [31:0] last_rdata_m = 32'd0;
   logic        last_rw_m = 1'b0;
   bit          mon_en = 1'b1;
   bit          resp_en = 1'b1;
   int          force_wait = -1;
   int          last_wait = 0;
   int          rise_prev = 0;
   int          rise_last = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_bytes(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      if (f[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit m_fault(input logic [2:0] f, input logic rw, input logic [31:0] a);
      if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
      if (f[2] && rw) return 1'b1;
      if (a % m_bytes(f) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
      int mask;
      mask = (1 << m_bytes(f)) - 1;
      return 4'(mask << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
      longint unit;
      longint acc;
      int n;
      n = m_bytes(f);
      unit = longint'(w) % (64'd1 << (8 * n));
      acc = 0;
      for (int k = 0; k < 4 / n; k++) acc = acc + (unit << (8 * n * k));
      return acc[31:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
      longint v;
      int n;
      n = m_bytes(f);
      if (n == 4) return word;
      v = (longint'(word) >> (8 * (a % 4))) % (64'd1 << (8 * n));
      if (!f[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
      logic [3:0]  be;
      logic [31:0] lanes;
      logic [31:0] word;
      be = m_be(f, a);
      lanes = m_wdata(f, w);
      word = refmem[a[11:2]];
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = lanes[8*i +: 8];
      refmem[a[11:2]] = word;
   endtask

   // ---------------- memory responder ----------------
   initial begin
      int w;
      logic [31:0] word;
      resp_ack = 1'b0;
      bus_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (resp_en && bus_req) begin
            w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            last_wait = w;
            repeat (w) @(negedge clk);
            word = busmem[bus_addr[11:2]];
            if (bus_we) begin
               for (int i = 0; i < 4; i++) if (bus_be[i]) word[8*i +: 8] = bus_wdata[8*i +: 8];
               busmem[bus_addr[11:2]] = word;
            end
            bus_rdata = word;
            resp_ack = 1'b1;
            @(negedge clk);
            resp_ack = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   logic        prev_req = 1'b0;
   logic [31:0] cap_addr;
   logic [3:0]  cap_be;
   logic        cap_we;
   logic [31:0] cap_wdata;

   always @(negedge clk) begin
      bus_exp_t be_e;
      res_exp_t re_e;
      if (mon_en) begin
         if (bus_req && !prev_req) begin
            rise_prev = rise_last;
            rise_last = cyc;
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected actual=req required=none t=%0t", $time);
            end else begin
               be_e = bus_q.pop_front();
               chk("bus_addr", bus_addr, be_e.addr);
               chk("bus_be", 32'(bus_be), 32'(be_e.be));
               chk("bus_we", 32'(bus_we), 32'(be_e.we));
               if (be_e.we) chk("bus_wdata", bus_wdata, be_e.wdata);
            end
            cap_addr = bus_addr;
            cap_be = bus_be;
            cap_we = bus_we;
            cap_wdata = bus_wdata;
         end else if (bus_req) begin
            chk("stable_addr", bus_addr, cap_addr);
            chk("stable_be", 32'(bus_be), 32'(cap_be));
            chk("stable_we", 32'(bus_we), 32'(cap_we));
            chk("stable_wdata", bus_wdata, cap_wdata);
         end else if (prev_req) begin
            if (res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL res_unexpected actual=done required=none t=%0t", $time);
            end else begin
               re_e = res_q.pop_front();
               chk("mem_rw_o", 32'(mem_rw_o), 32'(re_e.rw));
               chk("mem_rdata_o", mem_rdata_o, re_e.rdata);
               chk("busy_done", 32'(busy), 32'd0);
            end
         end
      end
      prev_req = bus_req;
   end

   // ---------------- driver ----------------
   // Called at a negedge with the FSM in IDLE; returns at a negedge with the
   // FSM in IDLE and ex_valid low.
   task automatic issue(input logic rw, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input bit ena);
      bit flt;
      int busy_n;
      int t;
      bit seen;
      bus_exp_t be_e;
      res_exp_t re_e;
      ex_valid = 1'b1;
      ex_mem_ena = ena;
      ex_mem_rw = rw;
      ex_funct3 = f;
      ex_addr = a;
      ex_wdata = wd;
      flt = ena && m_fault(f, rw, a);
      #1;
      chk("mem_fault", 32'(mem_fault), 32'(flt));
      if (!ena || flt) begin
         chk("busy_noacc", 32'(busy), 32'd0);
         @(negedge clk);
         chk("no_req", 32'(bus_req), 32'd0);
         ex_valid = 1'b0;
         return;
      end
      be_e.addr = {a[31:2], 2'b00};
      be_e.be = m_be(f, a);
      be_e.we = rw;
      be_e.wdata = m_wdata(f, wd);
      bus_q.push_back(be_e);
      if (rw) begin
         m_store(f, a, wd);
      end else begin
         last_rdata_m = m_load(f, a, refmem[a[11:2]]);
      end
      last_rw_m = rw;
      re_e.rw = rw;
      re_e.rdata = last_rdata_m;
      res_q.push_back(re_e);
      busy_n = busy ? 1 : 0;
      seen = 1'b0;
      for (t = 0; t < 60; t++) begin
         @(negedge clk);
         if (bus_req) begin
            seen = 1'b1;
            busy_n += busy ? 1 : 0;
         end else if (seen) begin
            break;
         end
      end
      chk("done_in_time", 32'(t < 60), 32'd1);
      chk("busy_cycles", busy_n, 2 + last_wait);
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] held;
      logic [31:0] ra;
      logic [2:0]  rf;
      logic        rrw;
      int          nb;
      for (int i = 0; i < 1024; i++) begin
         v = $urandom;
         refmem[i] = v;
         busmem[i] = v;
      end
      refmem[32'h100 >> 2] = 32'hDEADBEEF;
      busmem[32'h100 >> 2] = 32'hDEADBEEF;
      refmem[32'h100 >> 2 | 0] = 32'hDEADBEEF;
      refmem[32'h103 >> 2] = 32'hDEADBEEF;
      refmem[32'h104 >> 2] = 32'h80112233;
      busmem[32'h104 >> 2] = 32'h80112233;

      rst = 1'b1;
      man_ack = 1'b0;
      ex_valid = 1'b0;
      ex_mem_ena = 1'b0;
      ex_mem_rw = 1'b0;
      ex_funct3 = 3'd0;
      ex_addr = 32'd0;
      ex_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_be", 32'(bus_be), 32'd0);
      chk("rst_rdata", mem_rdata_o, 32'd0);
      chk("rst_rw", 32'(mem_rw_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // LW 0x100, zero wait states
      force_wait = 0;
      issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b1);
      chk("lw_rdata", mem_rdata_o, 32'hDEADBEEF);
      chk("lw_rw", 32'(mem_rw_o), 32'd0);

      // LB / LBU at 0x107 (lane 3 of 0x80112233)
      issue(1'b0, 3'b000, 32'h107, 32'd0, 1'b1);
      chk("lb_rdata", mem_rdata_o, 32'hFFFFFF80);
      issue(1'b0, 3'b100, 32'h107, 32'd0, 1'b1);
      chk("lbu_rdata", mem_rdata_o, 32'h00000080);

      // SH at 0x202 with three wait states
      force_wait = 3;
      issue(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1'b1);
      chk("sh_rdata_kept", mem_rdata_o, 32'h00000080);
      chk("sh_rw", 32'(mem_rw_o), 32'd1);

      // Misaligned word load
      issue(1'b0, 3'b010, 32'h101, 32'd0, 1'b1);

      // Reset in the second REQ cycle of a load
      mon_en = 1'b0;
      resp_en = 1'b0;
      ex_valid = 1'b1;
      ex_mem_ena = 1'b1;
      ex_mem_rw = 1'b0;
      ex_funct3 = 3'b010;
      ex_addr = 32'h104;
      @(negedge clk);
      chk("rr_req1", 32'(bus_req), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      ex_valid = 1'b0;
      #1;
      chk("rr_req", 32'(bus_req), 32'd0);
      chk("rr_we", 32'(bus_we), 32'd0);
      chk("rr_addr", bus_addr, 32'd0);
      chk("rr_be", 32'(bus_be), 32'd0);
      chk("rr_wdata", bus_wdata, 32'd0);
      chk("rr_rdata", mem_rdata_o, 32'd0);
      chk("rr_rw", 32'(mem_rw_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      chk("rr_ack_ignored", mem_rdata_o, 32'd0);
      chk("rr_req_after", 32'(bus_req), 32'd0);
      last_rdata_m = 32'd0;
      last_rw_m = 1'b0;
      mon_en = 1'b1;
      resp_en = 1'b1;

      // Back-to-back SW then LW
      force_wait = 0;
      issue(1'b1, 3'b010, 32'h300, 32'h11223344, 1'b1);
      issue(1'b0, 3'b010, 32'h300, 32'd0, 1'b1);
      chk("b2b_gap", rise_last - rise_prev, 32'd3);
      chk("b2b_rdata", mem_rdata_o, 32'h11223344);

      // Randomized traffic
      force_wait = -1;
      for (int n = 0; n < 300; n++) begin
         rrw = 1'($urandom_range(0, 1));
         rf = 3'($urandom_range(0, 7));
         ra = $urandom_range(0, 4095);
         if ($urandom_range(0, 9) < 7) begin
            nb = m_bytes(rf);
            ra = ra - (ra % nb);
         end
         held = $urandom;
         issue(rrw, rf, ra, held, $urandom_range(0, 9) != 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("bus_q_empty", bus_q.size(), 32'd0);
      chk("res_q_empty", res_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
